neopix_frame_sequencer: RTL and testbench
=========================================

Name: neopix_frame_sequencer

Overview:
- Read-side controller for the 512x32 pixel RAM, whose read port has a 2-cycle registered read latency.
- On a start pulse it walks a contiguous, wrapping window of pixel words and streams them to the NeoPixel bit encoder over a valid/ready handshake.
- After the last word is accepted it holds the WS2812 latch/reset gap, then signals frame completion.
- The SPI write side owns the RAM write port; this block only drives the read address.

Parameters:
- ADDR_W, 9, RAM address width (512 words)
- DATA_W, 32, RAM word width; bits [23:0] carry GRB, bits [31:24] are passed through
- RD_LATENCY, 2, cycles from rdaddress sampled to q valid
- FIFO_DEPTH, 4, output buffer entries; must be >= RD_LATENCY+1
- LATCH_CYCLES, 2500, latch gap length in clocks (50 us at 50 MHz)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame request
- base_addr  in  ADDR_W  first RAM word of the frame; sampled on accepted start
- pixel_count  in  ADDR_W+1  words in the frame, 0..512; sampled on accepted start
- rdaddress  out  ADDR_W  RAM read address (registered)
- ram_q  in  DATA_W  RAM read data
- pix_data  out  DATA_W  pixel word to the encoder
- pix_valid  out  1  pix_data is valid
- pix_ready  in  1  encoder accepts the word when valid&&ready
- latch  out  1  high for the whole latch gap
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Clock and reset: one clock, clock. Reset is asynchronous and active-low on reset_n. Reset values: rdaddress=0, pix_valid=0, pix_data=0, latch=0, busy=0, done=0; FIFO, in-flight tracker and counters cleared.
- Read timing: rdaddress presented in cycle t is sampled at the end-of-t edge; ram_q is valid in cycle t+RD_LATENCY. A RD_LATENCY-bit valid shift register tags in-flight reads and pushes ram_q into the FIFO when its tag exits.
- Credit rule: issue a read only when (FIFO occupancy + in-flight count) < FIFO_DEPTH. The FIFO therefore never overflows. With ready held high, steady-state throughput is 1 word/clock.
- FIFO ordering: first-word-fall-through. pix_valid = FIFO not empty. pix_data = head entry. Pop on pix_valid&&pix_ready. Push and pop in the same cycle are allowed; occupancy stays unchanged.
- States:
  - IDLE: start with pixel_count>0 → FETCH, busy=1 from the next cycle. start with pixel_count==0 → done pulses the next cycle, no reads, no latch, stays IDLE.
  - FETCH: issue reads at base_addr+i mod 512, i=0..count-1. Address wraps 511→0. After the last issue → DRAIN.
  - DRAIN: wait until in-flight==0, FIFO empty and the last word has been accepted → LATCH.
  - LATCH: latch=1 for exactly LATCH_CYCLES clocks. On the final latch cycle the state goes → IDLE, and done=1 and busy=0 take effect in the next cycle.
- Input clamp: pixel_count > 512 is clamped to 512.
- start while busy: ignored, no queuing.
- pix_ready low for any duration: reads stall through the credit rule; no word is dropped or duplicated.
- Reset mid-frame: in-flight data is discarded and the block returns to IDLE with no done pulse.

Optional Feature:
- NEOPIX_AUTO_REFRESH_EN defined:
  - When LATCH completes, the block restarts FETCH using the sampled base_addr/pixel_count without passing through IDLE.
  - done still pulses once per frame and busy stays 1.
  - start is ignored while running.
  - Deasserting the new input port auto_stop (1 bit, in) returns the block to IDLE after the current latch.
- Not defined: auto_stop port is absent; the block is single-shot as described.

Decomposition:
- Shared package neopix_pkg holds:
  - state enum (IDLE, FETCH, DRAIN, LATCH)
  - defaults for ADDR_W, DATA_W, RD_LATENCY, LATCH_CYCLES
  - PIXEL_MAX=512
- One sub-module: neopix_pix_fifo, a parameterised FWFT FIFO (DEPTH, WIDTH) exposing occupancy for the credit check.

Test Plan:
- base=0, count=3, RAM[0..2]=A,B,C, ready=1 → first rdaddress 0 one cycle after start; A,B,C on pix_data in consecutive cycles; latch high 2500 cycles; then single done pulse.
- base=510, count=4 → rdaddress sequence 510,511,0,1; output order matches.
- count=8, ready toggled 1-of-3 cycles → all 8 words delivered once, in order; FIFO never exceeds 4 entries; rdaddress stalls while credits are exhausted.
- count=0 → done one cycle after start; no rdaddress change; latch never asserted.
- start re-pulsed in FETCH; count=700 → second start ignored; exactly 512 words streamed.
- reset_n low mid-FETCH of count=16 → all outputs at reset values immediately; no done; new start afterwards runs a clean frame.

Source files
------------

// File: rtl/neopix_pkg.sv
// Shared constants and FSM encoding for the NeoPixel frame sequencer.
// Defaults match a 512x32 pixel RAM with 2-cycle read latency at 50 MHz.
// No clocked logic.
package neopix_pkg;

  localparam int NEOPIX_ADDR_W       = 9;
  localparam int NEOPIX_DATA_W       = 32;
  localparam int NEOPIX_RD_LATENCY   = 2;
  localparam int NEOPIX_LATCH_CYCLES = 2500;
  localparam int PIXEL_MAX           = 512;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_LATCH = 2'd3;

endpackage

// File: rtl/neopix_pix_fifo.sv
// First-word-fall-through FIFO; exposes occupancy so the reader can run a credit check.
// Latency: a push is visible at the head in the following cycle.
// Backpressure: none internally; pushes while full are dropped, so the writer must respect count.
module neopix_pix_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Head is forced to zero when empty so the output is clean between frames.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/neopix_frame_sequencer.sv
// Streams a wrapping window of pixel RAM words to the encoder, then holds the WS2812 latch gap.
// Latency: first rdaddress one cycle after start, first pix_valid RD_LATENCY+2 cycles after start.
// Backpressure: pix_ready low stalls reads via occupancy+in-flight credits. NEOPIX_AUTO_REFRESH_EN adds auto_stop and free-running refresh.
module neopix_frame_sequencer
  import neopix_pkg::*;
#(
  parameter int ADDR_W       = NEOPIX_ADDR_W,
  parameter int DATA_W       = NEOPIX_DATA_W,
  parameter int RD_LATENCY   = NEOPIX_RD_LATENCY,
  parameter int FIFO_DEPTH   = 4,
  parameter int LATCH_CYCLES = NEOPIX_LATCH_CYCLES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   pixel_count,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              latch,
  output logic              busy,
  output logic              done
`ifdef NEOPIX_AUTO_REFRESH_EN
  ,
  input  logic              auto_stop
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  state_t                state;
  logic [ADDR_W:0]       remaining;
  logic [ADDR_W:0]       cnt_in;
  logic [LW-1:0]         latch_cnt;
  logic [RD_LATENCY-1:0] rd_sr;
  logic [CW:0]           inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  credit_ok;
  logic                  issue;
`ifdef NEOPIX_AUTO_REFRESH_EN
  logic [ADDR_W-1:0]     base_r;
  logic [ADDR_W:0]       count_r;
`endif

  assign cnt_in = (pixel_count > (ADDR_W+1)'(PIXEL_MAX)) ? (ADDR_W+1)'(PIXEL_MAX) : pixel_count;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + (CW+1)'(rd_sr[i]);
  end

  // Words already buffered plus words still in the RAM pipe must fit the FIFO.
  assign credit_ok = (({1'b0, fifo_count} + inflight) < (CW+1)'(FIFO_DEPTH));
  assign issue     = (state == ST_FETCH) && credit_ok;
  assign busy      = (state != ST_IDLE);
  assign latch     = (state == ST_LATCH);
  assign pix_valid = !fifo_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_sr <= '0;
    end else begin
      rd_sr[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) rd_sr[i] <= rd_sr[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rdaddress <= '0;
      remaining <= '0;
      latch_cnt <= '0;
      done      <= 1'b0;
`ifdef NEOPIX_AUTO_REFRESH_EN
      base_r    <= '0;
      count_r   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cnt_in == '0) begin
              done <= 1'b1;
            end else begin
              state     <= ST_FETCH;
              rdaddress <= base_addr;
              remaining <= cnt_in;
`ifdef NEOPIX_AUTO_REFRESH_EN
              base_r    <= base_addr;
              count_r   <= cnt_in;
`endif
            end
          end
        end
        ST_FETCH: begin
          if (issue) begin
            remaining <= remaining - 1'b1;
            // Address holds on the final read; ADDR_W-bit add wraps 511 -> 0.
            if (remaining == (ADDR_W+1)'(1)) state <= ST_DRAIN;
            else rdaddress <= rdaddress + 1'b1;
          end
        end
        ST_DRAIN: begin
          if ((inflight == '0) && fifo_empty) begin
            state     <= ST_LATCH;
            latch_cnt <= LW'(LATCH_CYCLES - 1);
          end
        end
        ST_LATCH: begin
          if (latch_cnt == '0) begin
            done <= 1'b1;
`ifdef NEOPIX_AUTO_REFRESH_EN
            if (auto_stop) begin
              state     <= ST_FETCH;
              rdaddress <= base_r;
              remaining <= count_r;
            end else begin
              state <= ST_IDLE;
            end
`else
            state <= ST_IDLE;
`endif
          end else begin
            latch_cnt <= latch_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  neopix_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_sr[RD_LATENCY-1]),
    .push_data (ram_q),
    .pop       (pix_valid && pix_ready),
    .pop_data  (pix_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_neopix_frame_sequencer.sv
// Directed bench for neopix_frame_sequencer with a 2-cycle registered RAM model.
module tb_neopix_frame_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [9:0]  pixel_count = '0;
  logic [8:0]  rdaddress;
  logic [31:0] ram_q = '0;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        latch;
  logic        busy;
  logic        done;

  localparam logic [31:0] WORD_A = 32'hFF12_3456;
  localparam logic [31:0] WORD_B = 32'h00AB_CDEF;
  localparam logic [31:0] WORD_C = 32'h7F00_FF00;

  neopix_frame_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .pixel_count (pixel_count),
    .rdaddress   (rdaddress),
    .ram_q       (ram_q),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .latch       (latch),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [512];
  logic [31:0] r1 = '0;
  always @(posedge clock) begin
    r1    <= mem[rdaddress];
    ram_q <= r1;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bit ready_mode = 1'b0;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      pix_ready = ready_mode ? ((cyc % 3) == 0) : 1'b1;
    end
  end

  // Cumulative observation log; each test snapshots indices before starting.
  logic [31:0] got_q [$];
  int          got_cyc [$];
  logic [8:0]  rd_q [$];
  int          rd_cyc [$];
  logic [8:0]  prev_rd = '0;
  logic        prev_latch = 1'b0;
  logic        busy_at_done = 1'b0;
  int latch_total = 0, latch_rise = 0, latch_last = 0;
  int done_cnt = 0, done_cyc = 0, max_occ = 0;

  always @(negedge clock) begin
    if (reset_n && pix_valid && pix_ready) begin
      got_q.push_back(pix_data);
      got_cyc.push_back(cyc);
    end
    if (rdaddress != prev_rd) begin
      rd_q.push_back(rdaddress);
      rd_cyc.push_back(cyc);
    end
    prev_rd = rdaddress;
    if (latch) begin
      latch_total++;
      latch_last = cyc;
      if (!prev_latch) latch_rise = cyc;
    end
    prev_latch = latch;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (int'(dut.fifo_count) > max_occ) max_occ = int'(dut.fifo_count);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int s, g0, r0, l0, d0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input int base, input int cnt);
    @(posedge clock);
    #1;
    g0 = got_q.size();
    r0 = rd_q.size();
    l0 = latch_total;
    d0 = done_cnt;
    base_addr   = 9'(base);
    pixel_count = 10'(cnt);
    start       = 1'b1;
    s           = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(posedge clock);
      n++;
    end
    check_val({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic check_words(input string tag, input int base, input int cnt);
    check_val({tag, "_nwords"}, 32'(got_q.size() - g0), 32'(cnt));
    for (int i = 0; i < cnt; i++)
      check_val($sformatf("%s_w%0d", tag, i), got_q[g0 + i], mem[(base + i) % 512]);
  endtask

  initial begin
    int dd;
    for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = WORD_A;
    mem[1] = WORD_B;
    mem[2] = WORD_C;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_rdaddress", 32'(rdaddress), 32'd0);
    check_val("rst_pix_valid", 32'(pix_valid), 32'd0);
    check_val("rst_pix_data",  pix_data,       32'd0);
    check_val("rst_latch",     32'(latch),     32'd0);
    check_val("rst_busy",      32'(busy),      32'd0);
    check_val("rst_done",      32'(done),      32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Basic three-word frame with exact timing
    pulse(0, 3);
    @(negedge clock);
    check_val("t1_rdaddr_s1", 32'(rdaddress), 32'd0);
    check_val("t1_busy_s1",   32'(busy),      32'd1);
    wait_done("t1");
    check_val("t1_nwords",  32'(got_q.size() - g0), 32'd3);
    check_val("t1_word_a",  got_q[g0],     WORD_A);
    check_val("t1_word_b",  got_q[g0 + 1], WORD_B);
    check_val("t1_word_c",  got_q[g0 + 2], WORD_C);
    check_val("t1_first_lat",  32'(got_cyc[g0] - s), 32'd4);
    check_val("t1_back2back",  32'(got_cyc[g0 + 2] - got_cyc[g0]), 32'd2);
    check_val("t1_latch_len",  32'(latch_total - l0), 32'd2500);
    check_val("t1_latch_start", 32'(latch_rise - s), 32'd8);
    check_val("t1_done_count", 32'(done_cnt - d0), 32'd1);
    check_val("t1_done_after_latch", 32'(done_cyc - latch_last), 32'd1);
    check_val("t1_busy_at_done", 32'(busy_at_done), 32'd0);

    // Address wrap 510,511,0,1
    pulse(510, 4);
    wait_done("t2");
    check_val("t2_nrd", 32'(rd_q.size() - r0), 32'd4);
    check_val("t2_rd0", 32'(rd_q[r0]),     32'd510);
    check_val("t2_rd1", 32'(rd_q[r0 + 1]), 32'd511);
    check_val("t2_rd2", 32'(rd_q[r0 + 2]), 32'd0);
    check_val("t2_rd3", 32'(rd_q[r0 + 3]), 32'd1);
    check_words("t2", 510, 4);

    // Backpressure: ready high one cycle in three
    ready_mode = 1'b1;
    pulse(40, 8);
    wait_done("t3");
    ready_mode = 1'b0;
    check_words("t3", 40, 8);
    check_val("t3_fifo_max_le4", 32'(max_occ <= 4), 32'd1);
    check_val("t3_rd_stalled", 32'((rd_cyc[r0 + 7] - s) > 8), 32'd1);

    // Zero-length frame
    pulse(77, 0);
    wait_done("t4");
    check_val("t4_done_lat",  32'(done_cyc - s), 32'd1);
    check_val("t4_no_rd",     32'(rd_q.size() - r0), 32'd0);
    check_val("t4_no_latch",  32'(latch_total - l0), 32'd0);
    check_val("t4_no_words",  32'(got_q.size() - g0), 32'd0);
    check_val("t4_done_once", 32'(done_cnt - d0), 32'd1);

    // Oversized count clamps to 512; re-pulsed start is ignored
    pulse(100, 700);
    repeat (10) @(posedge clock);
    #1;
    base_addr   = 9'd0;
    pixel_count = 10'd5;
    start       = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done("t5");
    check_words("t5", 100, 512);
    check_val("t5_done_once", 32'(done_cnt - d0), 32'd1);

    // Reset in the middle of a fetch
    pulse(200, 16);
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    dd = done_cnt;
    #1;
    check_val("t6_rdaddress", 32'(rdaddress), 32'd0);
    check_val("t6_pix_valid", 32'(pix_valid), 32'd0);
    check_val("t6_pix_data",  pix_data,       32'd0);
    check_val("t6_latch",     32'(latch),     32'd0);
    check_val("t6_busy",      32'(busy),      32'd0);
    check_val("t6_done",      32'(done),      32'd0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    check_val("t6_no_done", 32'(done_cnt - dd), 32'd0);
    check_val("t6_idle",    32'(busy), 32'd0);
    pulse(20, 2);
    wait_done("t6b");
    check_words("t6b", 20, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
